// File: rtl/rect_fill_writer_if.sv
// Command and RAM write-port bundle for rect_fill_writer.
// RECT_FILL_OUTLINE_EN adds the CMD_OUTLINE command bit.
interface rect_fill_writer_if #(
    parameter int X_LIMIT = 240,
    parameter int Y_LIMIT = 240
);
    localparam int XW = $clog2(X_LIMIT);
    localparam int YW = $clog2(Y_LIMIT);
    localparam int AW = XW + YW;

    // CMD_VALID/CMD_READY: a command transfers on the rising CLK edge where
    // both are high; the source holds all CMD_* fields stable while VALID is
    // high and not yet accepted, and VALID never waits on READY.
    logic          CMD_VALID;
    logic          CMD_READY;
    logic [XW-1:0] CMD_X0;
    logic [XW-1:0] CMD_X1;
    logic [YW-1:0] CMD_Y0;
    logic [YW-1:0] CMD_Y1;
    logic [7:0]    CMD_COLOR_R;
    logic [7:0]    CMD_COLOR_G;
    logic [7:0]    CMD_COLOR_B;
`ifdef RECT_FILL_OUTLINE_EN
    logic          CMD_OUTLINE;
`endif
    logic [AW-1:0] WRITE_RAM_ADDRESS;
    logic [7:0]    WRITE_RAM_COLOR_R;
    logic [7:0]    WRITE_RAM_COLOR_G;
    logic [7:0]    WRITE_RAM_COLOR_B;
    logic          WRITE_RAM;
    logic          BUSY;
    logic          DONE;

    modport master (
`ifdef RECT_FILL_OUTLINE_EN
        output CMD_OUTLINE,
`endif
        output CMD_VALID, CMD_X0, CMD_X1, CMD_Y0, CMD_Y1,
        output CMD_COLOR_R, CMD_COLOR_G, CMD_COLOR_B,
        input  CMD_READY, WRITE_RAM_ADDRESS, WRITE_RAM,
        input  WRITE_RAM_COLOR_R, WRITE_RAM_COLOR_G, WRITE_RAM_COLOR_B,
        input  BUSY, DONE
    );

    modport slave (
`ifdef RECT_FILL_OUTLINE_EN
        input  CMD_OUTLINE,
`endif
        input  CMD_VALID, CMD_X0, CMD_X1, CMD_Y0, CMD_Y1,
        input  CMD_COLOR_R, CMD_COLOR_G, CMD_COLOR_B,
        output CMD_READY, WRITE_RAM_ADDRESS, WRITE_RAM,
        output WRITE_RAM_COLOR_R, WRITE_RAM_COLOR_G, WRITE_RAM_COLOR_B,
        output BUSY, DONE
    );
endinterface

// File: rtl/rect_fill_writer.sv
// Rectangle fill engine: one raster-order pixel write per clock into the frame buffer.
// Optional RECT_FILL_OUTLINE_EN: write only the border pixels when CMD_OUTLINE is set.
module rect_fill_writer #(
    parameter int X_LIMIT = 240,
    parameter int Y_LIMIT = 240
) (
    input  logic              CLK,
    input  logic              RESET_N,
    rect_fill_writer_if.slave bus,
    output logic [1:0]        STATE_DBG
);
    localparam int XW = $clog2(X_LIMIT);
    localparam int YW = $clog2(Y_LIMIT);
    localparam int AW = XW + YW;
    localparam logic [31:0]   X_LIM_U  = X_LIMIT;
    localparam logic [31:0]   Y_LIM_U  = Y_LIMIT;
    localparam logic [XW-1:0] X_MAX    = XW'(X_LIMIT - 1);
    localparam logic [YW-1:0] Y_MAX    = YW'(Y_LIMIT - 1);
    localparam logic [AW-1:0] ROW_STEP = AW'(X_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t        state_q, state_n;
    logic [XW-1:0] x_q, x_n, x0_q, x0_n, x1_q, x1_n;
    logic [YW-1:0] y_q, y_n, y1_q, y1_n;
    logic [AW-1:0] row_q, row_n;
    logic [AW-1:0] addr_q, addr_n;
    logic [7:0]    r_q, r_n, g_q, g_n, b_q, b_n;
    logic          wr_q, wr_n, busy_q, busy_n, done_q, done_n;
`ifdef RECT_FILL_OUTLINE_EN
    logic [YW-1:0] y0_q, y0_n;
    logic          outline_q, outline_n;
`endif

    logic [XW-1:0] cx0, cx1;
    logic [YW-1:0] cy0, cy1;
    logic          accept, empty, last_x, last_pix;

    // Out-of-range corners snap to the last visible column/row.
    assign cx0 = (32'(bus.CMD_X0) >= X_LIM_U) ? X_MAX : bus.CMD_X0;
    assign cx1 = (32'(bus.CMD_X1) >= X_LIM_U) ? X_MAX : bus.CMD_X1;
    assign cy0 = (32'(bus.CMD_Y0) >= Y_LIM_U) ? Y_MAX : bus.CMD_Y0;
    assign cy1 = (32'(bus.CMD_Y1) >= Y_LIM_U) ? Y_MAX : bus.CMD_Y1;

    assign accept   = bus.CMD_VALID && (state_q == S_IDLE);
    assign empty    = (cx0 > cx1) || (cy0 > cy1);
    assign last_x   = (x_q == x1_q);
    assign last_pix = last_x && (y_q == y1_q);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state_q <= S_IDLE;
        else          state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        x_n     = x_q;
        y_n     = y_q;
        x0_n    = x0_q;
        x1_n    = x1_q;
        y1_n    = y1_q;
        row_n   = row_q;
        addr_n  = addr_q;
        r_n     = r_q;
        g_n     = g_q;
        b_n     = b_q;
        wr_n    = 1'b0;
        busy_n  = busy_q;
        done_n  = 1'b0;
`ifdef RECT_FILL_OUTLINE_EN
        y0_n      = y0_q;
        outline_n = outline_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    busy_n = 1'b1;
                    x0_n   = cx0;
                    x1_n   = cx1;
                    y1_n   = cy1;
                    x_n    = cx0;
                    y_n    = cy0;
                    row_n  = AW'(32'(cy0) * X_LIM_U);
`ifdef RECT_FILL_OUTLINE_EN
                    y0_n      = cy0;
                    outline_n = bus.CMD_OUTLINE;
`endif
                    if (empty) begin
                        state_n = S_FIN;
                        done_n  = 1'b1;
                    end else begin
                        // The first pixel (X0,Y0) is always on the border.
                        state_n = S_FILL;
                        wr_n    = 1'b1;
                        addr_n  = row_n + AW'(cx0);
                        r_n     = bus.CMD_COLOR_R;
                        g_n     = bus.CMD_COLOR_G;
                        b_n     = bus.CMD_COLOR_B;
                    end
                end
            end
            S_FILL: begin
                if (last_pix) begin
                    state_n = S_FIN;
                    done_n  = 1'b1;
                end else begin
                    if (last_x) begin
                        x_n   = x0_q;
                        y_n   = y_q + 1'b1;
                        row_n = row_q + ROW_STEP;
                    end else begin
                        x_n = x_q + 1'b1;
                    end
                    addr_n = row_n + AW'(x_n);
`ifdef RECT_FILL_OUTLINE_EN
                    wr_n = !outline_q || (x_n == x0_q) || (x_n == x1_q) ||
                           (y_n == y0_q) || (y_n == y1_q);
`else
                    wr_n = 1'b1;
`endif
                end
            end
            S_FIN: begin
                state_n = S_IDLE;
                busy_n  = 1'b0;
            end
            default: begin
                state_n = S_IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            x_q    <= '0;
            y_q    <= '0;
            x0_q   <= '0;
            x1_q   <= '0;
            y1_q   <= '0;
            row_q  <= '0;
            addr_q <= '0;
            r_q    <= '0;
            g_q    <= '0;
            b_q    <= '0;
            wr_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
`ifdef RECT_FILL_OUTLINE_EN
            y0_q      <= '0;
            outline_q <= 1'b0;
`endif
        end else begin
            x_q    <= x_n;
            y_q    <= y_n;
            x0_q   <= x0_n;
            x1_q   <= x1_n;
            y1_q   <= y1_n;
            row_q  <= row_n;
            addr_q <= addr_n;
            r_q    <= r_n;
            g_q    <= g_n;
            b_q    <= b_n;
            wr_q   <= wr_n;
            busy_q <= busy_n;
            done_q <= done_n;
`ifdef RECT_FILL_OUTLINE_EN
            y0_q      <= y0_n;
            outline_q <= outline_n;
`endif
        end
    end

    assign bus.CMD_READY         = (state_q == S_IDLE);
    assign bus.WRITE_RAM_ADDRESS = addr_q;
    assign bus.WRITE_RAM_COLOR_R = r_q;
    assign bus.WRITE_RAM_COLOR_G = g_q;
    assign bus.WRITE_RAM_COLOR_B = b_q;
    assign bus.WRITE_RAM         = wr_q;
    assign bus.BUSY              = busy_q;
    assign bus.DONE              = done_q;
    assign STATE_DBG             = state_q;
endmodule

// File: tb/tb_rect_fill_writer.sv
// Self-checking bench for rect_fill_writer: pixel scoreboard plus per-command timing checks.
module tb_rect_fill_writer;
    localparam int X_LIMIT = 240;
    localparam int Y_LIMIT = 240;
    localparam int XW = $clog2(X_LIMIT);
    localparam int YW = $clog2(Y_LIMIT);
    localparam int AW = XW + YW;
    localparam int EW = AW + 24;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic [1:0] state_dbg;

    rect_fill_writer_if #(.X_LIMIT(X_LIMIT), .Y_LIMIT(Y_LIMIT)) bus ();

    rect_fill_writer #(.X_LIMIT(X_LIMIT), .Y_LIMIT(Y_LIMIT)) dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .bus      (bus),
        .STATE_DBG(state_dbg)
    );

    always #5 CLK = ~CLK;

    int              n_chk = 0;
    int              n_err = 0;
    logic [EW-1:0]   exp_q[$];
    logic [23:0]     last_rgb = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every strobed write must match the next expected pixel.
    always @(negedge CLK) begin
        if (RESET_N === 1'b1 && bus.WRITE_RAM === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_write", 64'(bus.WRITE_RAM_ADDRESS), 64'hFFFF_FFFF);
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                check("pixel", {bus.WRITE_RAM_ADDRESS, bus.WRITE_RAM_COLOR_R,
                                bus.WRITE_RAM_COLOR_G, bus.WRITE_RAM_COLOR_B}, e);
            end
        end
    end

    // Reference model: clamp, then plain nested raster loop with a multiply.
    task automatic push_rect(input int x0, input int x1, input int y0, input int y1,
                             input logic [23:0] rgb, input bit outline,
                             output int n_scan, output int n_wr);
        logic [AW-1:0] a;
        if (x0 >= X_LIMIT) x0 = X_LIMIT - 1;
        if (x1 >= X_LIMIT) x1 = X_LIMIT - 1;
        if (y0 >= Y_LIMIT) y0 = Y_LIMIT - 1;
        if (y1 >= Y_LIMIT) y1 = Y_LIMIT - 1;
        n_scan = 0;
        n_wr   = 0;
        if (x0 <= x1 && y0 <= y1) begin
            for (int y = y0; y <= y1; y++) begin
                for (int x = x0; x <= x1; x++) begin
                    n_scan++;
                    if (!outline || x == x0 || x == x1 || y == y0 || y == y1) begin
                        a = AW'(y * X_LIMIT + x);
                        exp_q.push_back({a, rgb});
                        n_wr++;
                    end
                end
            end
        end
    endtask

    task automatic drive_cmd(input int x0, input int x1, input int y0, input int y1,
                             input logic [23:0] rgb, input bit outline);
        bus.CMD_X0      = XW'(x0);
        bus.CMD_X1      = XW'(x1);
        bus.CMD_Y0      = YW'(y0);
        bus.CMD_Y1      = YW'(y1);
        bus.CMD_COLOR_R = rgb[23:16];
        bus.CMD_COLOR_G = rgb[15:8];
        bus.CMD_COLOR_B = rgb[7:0];
`ifdef RECT_FILL_OUTLINE_EN
        bus.CMD_OUTLINE = outline;
`else
        if (outline) $display("note: outline request ignored in solid-only build");
`endif
        bus.CMD_VALID   = 1'b1;
    endtask

    task automatic wait_accept();
        int g = 0;
        while (bus.CMD_READY !== 1'b1 && g < 200) begin
            @(negedge CLK);
            g++;
        end
        if (g >= 200) check("accept_timeout", 64'd0, 64'd1);
        @(posedge CLK);
        #1 bus.CMD_VALID = 1'b0;
    endtask

    // Called just after the accepting edge; walks the command cycle by cycle.
    task automatic track(input int n_scan, input int n_wr, input logic [23:0] hold_rgb);
        int  writes = 0, busy = 0, ready_bad = 0, done_cyc = 0;
        for (int cyc = 1; cyc <= n_scan + 6; cyc++) begin
            @(negedge CLK);
            if (cyc == 1) check("first_cycle_write", 64'(bus.WRITE_RAM), 64'(n_wr > 0));
            if (bus.WRITE_RAM === 1'b1) writes++;
            if (bus.BUSY === 1'b1)      busy++;
            if (bus.CMD_READY !== 1'b0) ready_bad++;
            if (bus.DONE === 1'b1) begin
                done_cyc = cyc;
                break;
            end
        end
        check("done_cycle", 64'(done_cyc), 64'(n_scan + 1));
        check("write_count", 64'(writes), 64'(n_wr));
        check("busy_cycles", 64'(busy), 64'(n_scan + 1));
        check("ready_low_while_busy", 64'(ready_bad), 64'd0);
        @(negedge CLK);
        check("idle_after_done", {bus.CMD_READY, bus.DONE, bus.BUSY, bus.WRITE_RAM}, 4'b1000);
        check("color_hold", {bus.WRITE_RAM_COLOR_R, bus.WRITE_RAM_COLOR_G,
                             bus.WRITE_RAM_COLOR_B}, hold_rgb);
    endtask

    task automatic run(input int x0, input int x1, input int y0, input int y1,
                       input logic [23:0] rgb, input bit outline);
        int ns, nw;
        push_rect(x0, x1, y0, y1, rgb, outline, ns, nw);
        drive_cmd(x0, x1, y0, y1, rgb, outline);
        wait_accept();
        if (ns > 0) last_rgb = rgb;
        track(ns, nw, last_rgb);
    endtask

    initial begin
        int ns_a, nw_a, ns_b, nw_b, w, g, done_seen;
        logic [23:0] rgb_a, rgb_b;
        RESET_N       = 1'b0;
        bus.CMD_VALID = 1'b0;
        bus.CMD_X0 = '0; bus.CMD_X1 = '0; bus.CMD_Y0 = '0; bus.CMD_Y1 = '0;
        bus.CMD_COLOR_R = '0; bus.CMD_COLOR_G = '0; bus.CMD_COLOR_B = '0;
`ifdef RECT_FILL_OUTLINE_EN
        bus.CMD_OUTLINE = 1'b0;
`endif
        repeat (3) @(negedge CLK);
        check("rst_outputs", {bus.WRITE_RAM_ADDRESS, bus.WRITE_RAM_COLOR_R, bus.WRITE_RAM_COLOR_G,
                              bus.WRITE_RAM_COLOR_B, bus.WRITE_RAM, bus.BUSY, bus.DONE}, 64'd0);
        check("rst_ready", 64'(bus.CMD_READY), 64'd1);
        check("rst_state", 64'(state_dbg), 64'd0);
        RESET_N = 1'b1;

        run(5, 5, 3, 3, 24'h123456, 1'b0);           // single pixel at 725
        run(10, 12, 0, 1, 24'hA0B0C0, 1'b0);         // 10,11,12,250,251,252
        run(238, 255, 239, 239, 24'h0F0F0F, 1'b0);   // x clip: 57598,57599
        run(0, 1, 250, 255, 24'h010203, 1'b0);       // y clip: 57360,57361
        run(20, 10, 4, 4, 24'hDEAD00, 1'b0);         // empty in x
        run(3, 3, 9, 2, 24'h00BEEF, 1'b0);           // empty in y

        // Second command held valid during the first fill must wait for IDLE.
        rgb_a = 24'h111111;
        rgb_b = 24'h222222;
        push_rect(100, 103, 50, 51, rgb_a, 1'b0, ns_a, nw_a);
        drive_cmd(100, 103, 50, 51, rgb_a, 1'b0);
        wait_accept();
        push_rect(7, 8, 200, 202, rgb_b, 1'b0, ns_b, nw_b);
        drive_cmd(7, 8, 200, 202, rgb_b, 1'b0);
        track(ns_a, nw_a, rgb_a);
        wait_accept();
        last_rgb = rgb_b;
        track(ns_b, nw_b, rgb_b);

        for (int i = 0; i < 4; i++) begin
            int rx, ry;
            rx = $urandom_range(0, 239);
            ry = $urandom_range(0, 239);
            run(rx, rx + $urandom_range(0, 5), ry, ry + $urandom_range(0, 3),
                24'($urandom_range(0, 24'hFFFFFF)), 1'b0);
        end

        // Full-screen fill aborted by reset after 100 writes.
        push_rect(0, 239, 0, 239, 24'h777777, 1'b0, ns_a, nw_a);
        drive_cmd(0, 239, 0, 239, 24'h777777, 1'b0);
        wait_accept();
        w = 0;
        g = 0;
        while (w < 100 && g < 1000) begin
            @(negedge CLK);
            g++;
            if (bus.WRITE_RAM === 1'b1) w++;
        end
        check("abort_reached_100", 64'(w), 64'd100);
        #2 RESET_N = 1'b0;
        #1;
        check("abort_async_clear", {bus.WRITE_RAM, bus.BUSY, bus.DONE, bus.CMD_READY}, 4'b0001);
        check("abort_state", 64'(state_dbg), 64'd0);
        done_seen = 0;
        repeat (3) begin
            @(negedge CLK);
            if (bus.DONE === 1'b1 || bus.WRITE_RAM === 1'b1) done_seen++;
        end
        check("abort_no_done", 64'(done_seen), 64'd0);
        exp_q.delete();
        last_rgb = '0;
        @(negedge CLK);
        RESET_N = 1'b1;
        run(5, 5, 3, 3, 24'h123456, 1'b0);

`ifdef RECT_FILL_OUTLINE_EN
        run(0, 2, 0, 2, 24'h5A5A5A, 1'b1);           // 9 scans, 241 skipped
        run(30, 35, 10, 13, 24'h00FF00, 1'b1);
        run(30, 31, 10, 11, 24'h0000FF, 1'b0);
`endif

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/rect_fill_writer.md
Name: rect_fill_writer

Overview:
- Upstream write stage for the frame buffer RAM. Accepts one rectangle-fill command at a time (corners plus RGB888 colour).
- Emits one pixel write per clock on the buffer RAM write port: linear address, R/G/B, write strobe.
- Lets the animation logic draw or clear regions without per-pixel addressing. The painter meanwhile reads the same buffer.

Parameters:
- X_LIMIT, 240, display width in pixels.
- Y_LIMIT, 240, display height in pixels.
- Derived widths: XW = $clog2(X_LIMIT), YW = $clog2(Y_LIMIT), AW = XW+YW.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  block can accept a command.
- CMD_X0 / CMD_X1  in  XW  left / right column, inclusive.
- CMD_Y0 / CMD_Y1  in  YW  top / bottom row, inclusive.
- CMD_COLOR_R / CMD_COLOR_G / CMD_COLOR_B  in  8 each  fill colour.
- WRITE_RAM_ADDRESS  out  AW  linear pixel index y*X_LIMIT + x.
- WRITE_RAM_COLOR_R / _G / _B  out  8 each  pixel colour.
- WRITE_RAM  out  1  write strobe.
- BUSY  out  1  fill in progress.
- DONE  out  1  single-cycle pulse at end of each command.

Behaviour:
- Reset (async assert, sync release): state IDLE. WRITE_RAM_ADDRESS, all colour outputs, WRITE_RAM, BUSY and DONE are 0. CMD_READY=1 whenever state is IDLE, including while reset is held.
- Reset asserted mid-fill: abort immediately, no further writes, no DONE.
- Handshake: command accepted on the rising edge where CMD_VALID && CMD_READY. CMD_READY = (state==IDLE), so it is 0 in FILL and FIN. Command fields are registered on acceptance; input changes afterwards are ignored.
- Clipping at accept: any coordinate >= X_LIMIT (x) or >= Y_LIMIT (y) is clamped to X_LIMIT-1 / Y_LIMIT-1.
- Empty command: if clamped X0>X1 or Y0>Y1, go IDLE->FIN directly. Zero writes; DONE pulses in the cycle after acceptance.
- States:
  - IDLE: on accept, go to FILL (or FIN if empty).
  - FILL: one pixel per cycle, raster order. x runs X0..X1 within each row; y runs Y0..Y1. Go to FIN after pixel (X1,Y1).
  - FIN: DONE=1 for one cycle, then IDLE.
- Timing:
  - First write: WRITE_RAM=1 with address Y0*X_LIMIT+X0 in the cycle after acceptance (registered outputs, latency 1).
  - N=(X1-X0+1)*(Y1-Y0+1) consecutive write cycles, no gaps.
  - DONE is high in the cycle after the last write.
  - Next command can be accepted in the cycle after DONE, i.e. back-to-back throughput is N+2 cycles.
- BUSY=1 from the cycle after acceptance through the DONE cycle inclusive.
- Address generation: no multiplier in the pixel loop. A row-base register is loaded with Y0*X_LIMIT at accept (constant multiply) and incremented by X_LIMIT at each row wrap. Address = row_base + x, AW bits. Maximum index X_LIMIT*Y_LIMIT-1 never overflows.
- Colour outputs hold the registered command colour during FILL and hold their last value otherwise. WRITE_RAM=0 outside FILL.

Optional Feature:
- Macro: RECT_FILL_OUTLINE_EN.
- Defined:
  - Adds input port CMD_OUTLINE (1 bit), registered at accept.
  - When 1, WRITE_RAM is asserted only for border pixels (x==X0, x==X1, y==Y0 or y==Y1).
  - Interior pixels are still scanned with WRITE_RAM=0, so the cycle count stays N and timing is identical to a solid fill.
- Not defined: port absent; every pixel in the rectangle is written.

Test Plan:
- Reset then single pixel. Release RESET_N; cmd X0=X1=5, Y0=Y1=3, colour (0x12,0x34,0x56).
  - Response: one WRITE_RAM cycle, address 725, colour (0x12,0x34,0x56), next cycle DONE=1, then CMD_READY=1.
- 3x2 rectangle X 10..12, Y 0..1.
  - Response: addresses 10,11,12,250,251,252 on consecutive cycles; BUSY high for 7 cycles; DONE once.
- Clipping. X0=238, X1=255, Y0=Y1=239.
  - Response: addresses 57598, 57599 only.
- Empty and blocked commands.
  - X0=20, X1=10: zero writes, DONE one cycle after accept.
  - CMD_VALID held during FILL: not accepted until IDLE.
- Reset mid-fill. Full-screen fill, assert RESET_N low at write 100.
  - Response: WRITE_RAM drops to 0 asynchronously, no DONE; a new command after release runs normally.
- RECT_FILL_OUTLINE_EN defined, CMD_OUTLINE=1, X 0..2, Y 0..2.
  - Response: 9 scan cycles, 8 writes, address 241 skipped.
